// File: rtl/fma_norm_round_pkg.sv
// Shared constants and types for the FMA post-addition normalize/round stage.
//   DEF_*        default datapath widths used by fma_norm_round
//   FLAG_*       bit positions inside out_flags
//   flags_t      packed view of out_flags: {overflow, underflow, inexact, zero}
package fma_norm_round_pkg;

    localparam int DEF_ADDER_WIDTH = 48;
    localparam int DEF_MAN_WIDTH   = 23;
    localparam int DEF_EXP_WIDTH   = 8;

    localparam int FLAG_OVERFLOW   = 3;
    localparam int FLAG_UNDERFLOW  = 2;
    localparam int FLAG_INEXACT    = 1;
    localparam int FLAG_ZERO       = 0;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } flags_t;

endpackage

// File: rtl/fma_norm_round_lzc.sv
// Combinational leading-zero counter.
//   value  in   WIDTH          vector to scan from the MSB
//   lz     out  clog2(WIDTH)   number of zeros above the leading one;
//                              an all-zero vector reports WIDTH-1 so that the
//                              normalizing shift never exceeds the vector width
module fma_norm_round_lzc #(
    parameter int WIDTH = 48
) (
    input  logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH)-1:0] lz
);

    localparam int LZW = $clog2(WIDTH);

    // Ascending scan: the highest set bit is the last one to write lz.
    always_comb begin
        lz = LZW'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                lz = LZW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fma_norm_round.sv
// FMA post-addition stage: complement fix-up, leading-zero normalize,
// round-to-nearest-even and exponent overflow/underflow handling, as a
// 3-stage pipeline (fix-up -> normalize -> round/output register).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; beat moves when both are high
//   sum, cout           raw adder result
//   sticky_in           OR of bits lost during alignment
//   effective_op        1 = effective subtraction
//   sign_in, exp_in     sign of larger operand, signed biased exponent of sum MSB
//   out_valid/out_ready output handshake
//   out_sign/exp/man    rounded result, hidden bit dropped
//   out_flags           {overflow, underflow, inexact, zero}
// Valid/ready: a beat transfers on a rising edge where valid & ready are both
// high; the whole pipeline advances together when the output slot is empty or
// being consumed, so in_ready equals that advance condition and out_* hold
// still while out_valid & ~out_ready.
module fma_norm_round
    import fma_norm_round_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int MAN_WIDTH   = DEF_MAN_WIDTH,
    parameter int EXP_WIDTH   = DEF_EXP_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] sum,
    input  logic                   cout,
    input  logic                   sticky_in,
    input  logic                   effective_op,
    input  logic                   sign_in,
    input  logic [EXP_WIDTH+1:0]   exp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [EXP_WIDTH-1:0]   out_exp,
    output logic [MAN_WIDTH-1:0]   out_man,
    output logic [3:0]             out_flags
);

    // One guard bit beyond the port exponent so +1 / -lz / +1 never wrap.
    localparam int XW  = EXP_WIDTH + 3;
    localparam int LZW = $clog2(ADDER_WIDTH);
    localparam int GB  = ADDER_WIDTH - 2 - MAN_WIDTH;   // guard bit index
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: complement / carry fix-up ----------------
    logic signed [XW-1:0]   exp_ext, fix_exp;
    logic [ADDER_WIDTH-1:0] fix_mag;
    logic                   fix_sign, fix_sticky, fix_zero;

    assign exp_ext = {exp_in[EXP_WIDTH+1], exp_in};

    always_comb begin
        fix_mag    = sum;
        fix_exp    = exp_ext;
        fix_sign   = sign_in;
        fix_sticky = sticky_in;
        if (!effective_op && cout) begin
            fix_mag    = {1'b1, sum[ADDER_WIDTH-1:1]};
            fix_exp    = exp_ext + XW'(1);
            fix_sticky = sticky_in | sum[0];
        end else if (effective_op && !cout) begin
            // No carry on subtraction means the result went negative.
            fix_mag  = ~sum + ADDER_WIDTH'(1);
            fix_sign = ~sign_in;
        end
        fix_zero = (fix_mag == '0) && !fix_sticky;
        // Exact cancellation under RNE yields +0.
        if (fix_zero) begin
            fix_sign = effective_op ? 1'b0 : sign_in;
        end
    end

    logic                   s1_valid, s1_sign, s1_sticky, s1_zero;
    logic signed [XW-1:0]   s1_exp;
    logic [ADDER_WIDTH-1:0] s1_mag;

    // ---------------- S2: normalize ----------------
    logic [LZW-1:0] lz;

    fma_norm_round_lzc #(.WIDTH(ADDER_WIDTH)) u_lzc (
        .value (s1_mag),
        .lz    (lz)
    );

    logic                   s2_valid, s2_sign, s2_sticky, s2_zero;
    logic signed [XW-1:0]   s2_exp;
    logic [ADDER_WIDTH-1:0] s2_mag;

    // ---------------- S3: round and exceptions ----------------
    logic [MAN_WIDTH-1:0] frac;
    logic [MAN_WIDTH:0]   frac_sum;
    logic                 guard, st, inc;
    logic signed [XW-1:0] rnd_exp;

    assign frac     = s2_mag[ADDER_WIDTH-2 -: MAN_WIDTH];
    assign guard    = s2_mag[GB];
    assign st       = (|s2_mag[GB-1:0]) | s2_sticky;
    assign inc      = guard & (st | frac[0]);
    assign frac_sum = {1'b0, frac} + {{MAN_WIDTH{1'b0}}, inc};
    // Fraction carry-out leaves frac_sum[MAN_WIDTH-1:0] == 0 already.
    assign rnd_exp  = s2_exp + $signed({{(XW-1){1'b0}}, frac_sum[MAN_WIDTH]});

    logic [EXP_WIDTH-1:0] res_exp;
    logic [MAN_WIDTH-1:0] res_man;
    flags_t               res_flags;

    always_comb begin
        res_exp   = '0;
        res_man   = '0;
        res_flags = '0;
        if (s2_zero) begin
            res_flags.zero = 1'b1;
        end else if (rnd_exp >= EXP_MAX) begin
            res_exp            = '1;
            res_flags.overflow = 1'b1;
            res_flags.inexact  = 1'b1;
        end else if (rnd_exp <= 0) begin
            res_flags.underflow = 1'b1;
            res_flags.inexact   = 1'b1;
        end else begin
            res_exp           = rnd_exp[EXP_WIDTH-1:0];
            res_man           = frac_sum[MAN_WIDTH-1:0];
            res_flags.inexact = guard | st;
        end
    end

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_sticky <= 1'b0;
            s1_zero   <= 1'b0;
            s1_exp    <= '0;
            s1_mag    <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_sticky <= 1'b0;
            s2_zero   <= 1'b0;
            s2_exp    <= '0;
            s2_mag    <= '0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sign   <= fix_sign;
            s1_sticky <= fix_sticky;
            s1_zero   <= fix_zero;
            s1_exp    <= fix_exp;
            s1_mag    <= fix_mag;

            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_sticky <= s1_sticky;
            s2_zero   <= s1_zero;
            s2_exp    <= s1_exp - $signed({{(XW-LZW){1'b0}}, lz});
            s2_mag    <= s1_mag << lz;

            out_valid <= s2_valid;
            if (s2_valid) begin
                out_sign  <= s2_sign;
                out_exp   <= res_exp;
                out_man   <= res_man;
                out_flags <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_fma_norm_round.sv
// Self-checking bench for fma_norm_round: directed corner cases, latency,
// stall/hold behaviour, reset mid-stream, and randomized beats against a
// numeric reference model.
module tb_fma_norm_round;

    localparam int W = 48;
    localparam int M = 23;
    localparam int E = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, cout, sticky_in, effective_op, sign_in;
    logic [W-1:0]   sum;
    logic [E+1:0]   exp_in;
    logic           out_valid, out_ready, out_sign;
    logic [E-1:0]   out_exp;
    logic [M-1:0]   out_man;
    logic [3:0]     out_flags;

    fma_norm_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sum          (sum),
        .cout         (cout),
        .sticky_in    (sticky_in),
        .effective_op (effective_op),
        .sign_in      (sign_in),
        .exp_in       (exp_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_man      (out_man),
        .out_flags    (out_flags)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Result packed as {sign, exp[7:0], man[22:0], flags[3:0]}.
    function automatic logic [35:0] ref_model(input logic [W-1:0] s, input logic c,
                                              input logic st, input logic eff,
                                              input logic sg, input logic [E+1:0] e);
        longint unsigned m, frac, rest;
        longint unsigned two_w;
        int              ex, lz;
        bit              sgn, stk, guard, inc;
        two_w = 64'd1 << W;
        ex    = int'($signed(e));
        sgn   = sg;
        stk   = st;
        m     = 64'(s);
        if (!eff && c) begin
            m   = (two_w + 64'(s)) / 2;
            stk = st | s[0];
            ex  = ex + 1;
        end else if (eff && !c) begin
            m   = (two_w - 64'(s)) % two_w;
            sgn = !sg;
        end
        if (m == 0 && !stk) return {(eff ? 1'b0 : sg), 8'd0, 23'd0, 4'b0001};
        lz = 0;
        while (lz < W - 1 && m < (64'd1 << (W - 1 - lz))) lz++;
        m     = (m << lz) % two_w;
        ex    = ex - lz;
        frac  = (m >> (W - 1 - M)) % (64'd1 << M);
        guard = ((m >> (W - 2 - M)) & 64'd1) != 0;
        rest  = m % (64'd1 << (W - 2 - M));
        inc   = guard && (rest != 0 || stk || (frac % 2) == 1);
        frac  = frac + 64'(inc);
        if (frac == (64'd1 << M)) begin
            frac = 0;
            ex   = ex + 1;
        end
        if (ex >= (1 << E) - 1) return {sgn, 8'hFF, 23'd0, 4'b1010};
        if (ex <= 0)            return {sgn, 8'd0, 23'd0, 4'b0110};
        return {sgn, 8'(ex), 23'(frac), 2'b00, (guard || rest != 0 || stk), 1'b0};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [35:0] exp_q[$];
    logic [35:0] held, last_out, e_val;
    bit          was_stalled = 0;
    int          n_out = 0;

    always @(negedge clk) begin
        if (rst) begin
            was_stalled = 0;
        end else begin
            if (was_stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_sign, out_exp, out_man, out_flags}), 64'(held));
            end
            if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(sum, cout, sticky_in, effective_op, sign_in, exp_in));
            if (out_valid && out_ready) begin
                last_out = {out_sign, out_exp, out_man, out_flags};
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(last_out), 64'hDEAD);
                end else begin
                    e_val = exp_q.pop_front();
                    check("result", 64'(last_out), 64'(e_val));
                end
            end
            was_stalled = out_valid && !out_ready;
            held        = {out_sign, out_exp, out_man, out_flags};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] s, input logic c, input logic st,
                         input logic eff, input logic sg, input logic [E+1:0] e);
        sum = s; cout = c; sticky_in = st; effective_op = eff; sign_in = sg; exp_in = e;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input logic [W-1:0] s, input logic c, input logic st,
                        input logic eff, input logic sg, input logic [E+1:0] e);
        int waited;
        drive(s, c, st, eff, sg, e);
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_random();
        logic [W-1:0] s;
        logic [E+1:0] e;
        s = W'({$urandom, $urandom}) >> $urandom_range(0, W - 1);
        if ($urandom_range(0, 15) == 0) s = '1;
        e = 10'($urandom_range(0, 300));
        send(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] s, input logic c,
                            input logic st, input logic eff, input logic sg,
                            input logic [E+1:0] e, input logic [35:0] want);
        send(s, c, st, eff, sg, e);
        wait_drain();
        check(tag, 64'(last_out), 64'(want));
    endtask

    // ---------------- main sequence ----------------
    int  lat, base;
    bit  done;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({out_sign, out_exp, out_man, out_flags}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Directed corner cases.
        directed("t1_plain",    48'h8000_0000_0000, 0, 0, 0, 0, 10'd127, {1'b0, 8'd127, 23'd0, 4'b0000});
        directed("t2_carry",    48'h0,              1, 0, 0, 0, 10'd127, {1'b0, 8'd128, 23'd0, 4'b0000});
        directed("t3_negate",   48'hFFFF_FFFF_FFFF, 0, 0, 1, 0, 10'd150, {1'b1, 8'd103, 23'd0, 4'b0000});
        directed("t4_tie_odd",  48'h8000_0180_0000, 0, 0, 0, 0, 10'd127, {1'b0, 8'd127, 23'd2, 4'b0010});
        directed("t4_tie_even", 48'h8000_0080_0000, 0, 0, 0, 0, 10'd127, {1'b0, 8'd127, 23'd0, 4'b0010});
        directed("t5_zero",     48'h0,              1, 0, 1, 1, 10'd100, {1'b0, 8'd0,   23'd0, 4'b0001});
        directed("t5_overflow", 48'h0,              1, 0, 0, 0, 10'd254, {1'b0, 8'd255, 23'd0, 4'b1010});
        directed("underflow",   48'h1,              0, 0, 0, 1, 10'd40,  {1'b1, 8'd0,   23'd0, 4'b0110});
        directed("round_carry", 48'hFFFF_FF80_0000, 0, 0, 0, 0, 10'd127, {1'b0, 8'd128, 23'd0, 4'b0010});

        // Latency with an idle pipeline.
        @(posedge clk); #1;
        drive(48'h9000_0000_0000, 0, 0, 0, 0, 10'd130);
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", 64'(lat), 64'd3);
        wait_drain();

        // Five back-to-back beats with out_ready low for cycles 3-7.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) send_random();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("hs_count", 64'(n_out - base), 64'd5);

        // Reset while beats are in flight.
        @(posedge clk); #1;
        drive(48'hC000_0000_0000, 0, 0, 0, 0, 10'd120);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(48'hA000_0000_0000, 0, 0, 0, 1, 10'd121);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end

        // Randomized beats with random back-pressure.
        base = n_out;
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) send_random();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("rand_count", 64'(n_out - base), 64'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
